if_stage: RTL and testbench
===========================

# if_stage

Instruction fetch stage of the pipelined RISC-V core. It holds the program counter and issues word fetches to instruction memory. It tracks the one outstanding request and loads the returned instruction word into the IF/ID pipeline register that feeds decode and the immediate generator. Stalls from hazard detection and redirects from branch/jump resolution are handled here, including discarding in-flight fetches made stale by a redirect.

## Interface

- N, 32, datapath/address width
- RESET_PC, 32'h0000_0000, PC value after reset
- NOP, 32'h0000_0013, bubble instruction (addi x0,x0,0)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request, accepted unconditionally in the cycle it is high
- imem_addr  out  N  fetch address (= pc)
- imem_rvalid  in  1  response valid, ≥1 cycle after request
- imem_rdata  in  N  instruction word, valid with imem_rvalid
- stall  in  1  decode cannot accept; IF/ID holds
- redirect  in  1  branch/jump taken; flush and refetch
- redirect_pc  in  N  new PC, valid with redirect
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_pc  out  N  PC of if_id_instr
- if_id_pc_plus4  out  N  if_id_pc + 4
- if_id_instr  out  N  instruction to decode

## Operation

- Registers: pc, state, hold_instr, IF/ID fields. At most one outstanding imem request.
- imem_req = (state==REQ) && !redirect; imem_addr = pc (combinational).
- Accept condition: accept = !stall. Redirect has priority over everything, including stall.
- States:
  - REQ: if redirect → pc<=redirect_pc, stay REQ, no request issued. Else issue request → WAIT.
  - WAIT: if redirect && rvalid → discard, pc<=redirect_pc → REQ. If redirect && !rvalid → pc<=redirect_pc → DROP. Else if rvalid && accept → load IF/ID {valid=1, pc, instr=rdata}, pc<=pc+4 → REQ. Else if rvalid && stall → hold_instr<=rdata → HOLD. Else stay.
  - HOLD: if redirect → discard hold_instr, pc<=redirect_pc → REQ. Else if !stall → load IF/ID from hold_instr, pc<=pc+4 → REQ.
  - DROP: if redirect → pc<=redirect_pc, stay DROP. Else if rvalid → discard → REQ.
- IF/ID update priority, per edge:
  1. redirect → valid=0, instr=NOP.
  2. Else stall → hold all fields.
  3. Else load when a response is delivered.
  4. Otherwise bubble: valid=0, instr=NOP, pc fields hold.
- if_id_pc_plus4 is registered with if_id_pc. Arithmetic is modulo 2^N: pc wraps from 0xFFFF_FFFC to 0.
- imem_rvalid in REQ or HOLD is a protocol violation and is ignored.

## Timing

- Reset (async assert, sync release): state=REQ, pc=RESET_PC, if_id_valid=0, if_id_pc=0, if_id_pc_plus4=4, if_id_instr=NOP, hold_instr=NOP, imem_req=1 combinationally once rst_n is high.
- Minimum fetch latency: request at cycle t, rvalid at t+1, IF/ID valid at t+2, next request at t+2. Steady throughput is one instruction per 2 cycles with a 1-cycle memory.
- Redirect at cycle t: IF/ID flushed at edge t+1. The first request to redirect_pc is issued at t+1, or after the stale response drains in DROP.
- Stall is level-sensitive. The instruction appears on IF/ID at the first edge where stall=0.
- Reset mid-WAIT/DROP: the outstanding response after reset arrives in REQ and is ignored.

## Test plan

- Reset, 1-cycle memory returning pc-indexed words → IF/ID shows PC 0,4,8 with valid=1 every 2 cycles; if_id_pc_plus4 = PC+4.
- Stall high for 3 cycles while rvalid arrives in WAIT → state HOLD. IF/ID unchanged during stall. The word appears at the first edge with stall=0, then next request at PC+4.
- Redirect to 0x100 in WAIT, rvalid 2 cycles later → response discarded, IF/ID valid=0/NOP, next imem_addr=0x100.
- Redirect to 0x200 in same cycle as rvalid → rdata never reaches IF/ID, next request at 0x200. Redirect together with stall → IF/ID still flushed.
- pc=0xFFFF_FFFC fetch → next imem_addr=0x0000_0000.
- rst_n low mid-WAIT, late rvalid after release → ignored. First request at RESET_PC, all outputs at reset values.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight, and
// fills the IF/ID register while honouring stalls and discarding fetches made stale by redirects.
module if_stage #(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [N-1:0] NOP      = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_rvalid,
    input  logic [N-1:0] imem_rdata,
    input  logic         stall,
    input  logic         redirect,
    input  logic [N-1:0] redirect_pc,
    output logic         if_id_valid,
    output logic [N-1:0] if_id_pc,
    output logic [N-1:0] if_id_pc_plus4,
    output logic [N-1:0] if_id_instr
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic [N-1:0] hold_instr_q, hold_instr_d;
    logic         if_id_valid_q, if_id_valid_d;
    logic [N-1:0] if_id_pc_q, if_id_pc_d;
    logic [N-1:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
    logic [N-1:0] if_id_instr_q, if_id_instr_d;

    logic         deliver;
    logic [N-1:0] deliver_instr;
    logic [N-1:0] pc_plus4;

    assign pc_plus4  = pc_q + N'(4);
    assign imem_req  = (state_q == S_REQ) && !redirect;
    assign imem_addr = pc_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_instr_d  = hold_instr_q;
        deliver       = 1'b0;
        deliver_instr = imem_rdata;

        case (state_q)
            S_REQ: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Without a response yet, a redirect must still swallow the stale one in DROP.
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid && !stall) begin
                    deliver       = 1'b1;
                    deliver_instr = imem_rdata;
                    pc_d          = pc_plus4;
                    state_d       = S_REQ;
                end else if (imem_rvalid) begin
                    hold_instr_d = imem_rdata;
                    state_d      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    hold_instr_d = NOP;
                    pc_d         = redirect_pc;
                    state_d      = S_REQ;
                end else if (!stall) begin
                    deliver       = 1'b1;
                    deliver_instr = hold_instr_q;
                    pc_d          = pc_plus4;
                    state_d       = S_REQ;
                end
            end
            S_DROP: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end else if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // Redirect flushes even under stall; otherwise stall freezes IF/ID and idle cycles insert bubbles.
    always_comb begin
        if_id_valid_d    = if_id_valid_q;
        if_id_pc_d       = if_id_pc_q;
        if_id_pc_plus4_d = if_id_pc_plus4_q;
        if_id_instr_d    = if_id_instr_q;

        if (redirect) begin
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP;
        end else if (stall) begin
            if_id_valid_d = if_id_valid_q;
        end else if (deliver) begin
            if_id_valid_d    = 1'b1;
            if_id_pc_d       = pc_q;
            if_id_pc_plus4_d = pc_plus4;
            if_id_instr_d    = deliver_instr;
        end else begin
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_REQ;
            pc_q             <= RESET_PC;
            hold_instr_q     <= NOP;
            if_id_valid_q    <= 1'b0;
            if_id_pc_q       <= '0;
            if_id_pc_plus4_q <= N'(4);
            if_id_instr_q    <= NOP;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            hold_instr_q     <= hold_instr_d;
            if_id_valid_q    <= if_id_valid_d;
            if_id_pc_q       <= if_id_pc_d;
            if_id_pc_plus4_q <= if_id_pc_plus4_d;
            if_id_instr_q    <= if_id_instr_d;
        end
    end

    assign if_id_valid    = if_id_valid_q;
    assign if_id_pc       = if_id_pc_q;
    assign if_id_pc_plus4 = if_id_pc_plus4_q;
    assign if_id_instr    = if_id_instr_q;

endmodule

// File: tb/tb_if_stage.sv
// Randomised bench for if_stage: a latency-variable memory model, a transaction-level
// fetch model feeding a scoreboard queue, and a monitor comparing IF/ID every cycle.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;

    if_stage #(.N(32), .RESET_PC(RESET_PC), .NOP(NOP)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_instr    (if_id_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct packed {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    exp_t  exp_q[$];
    mreq_t mem_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int loads    = 0;
    int lat_max  = 1;

    logic        mem_auto   = 1'b1;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata  = '0;
    logic        man_rvalid = 1'b0;
    logic [31:0] man_rdata  = '0;

    assign imem_rvalid = mem_auto ? mem_rvalid : man_rvalid;
    assign imem_rdata  = mem_auto ? mem_rdata  : man_rdata;

    // Model state: next address the core should fetch and the IF/ID content it should show.
    logic [31:0] exp_pc    = RESET_PC;
    bit          front_got = 1'b0;
    logic        m_valid   = 1'b0;
    logic [31:0] m_pc      = '0;
    logic [31:0] m_instr   = NOP;

    logic        s_rst, s_req, s_redir, s_stall, s_rvalid;
    logic [31:0] s_addr, s_rpc;
    bit          predicted;
    bit          observed;
    exp_t        e;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        s_rst    = rst_n;
        s_req    = imem_req;
        s_addr   = imem_addr;
        s_redir  = redirect;
        s_rpc    = redirect_pc;
        s_stall  = stall;
        s_rvalid = imem_rvalid;
        if (rst_n && imem_req)
            mem_q.push_back('{addr: imem_addr, due: cyc + $urandom_range(1, lat_max)});
        #1;
        if (!s_rst || !rst_n) begin
            exp_q.delete();
            front_got = 1'b0;
            exp_pc    = RESET_PC;
            m_valid   = 1'b0;
            m_pc      = '0;
            m_instr   = NOP;
        end else begin
            if (s_req)
                check_output("fetch_addr", s_addr, exp_pc);
            predicted = 1'b0;
            if (s_redir) begin
                exp_q.delete();
                front_got = 1'b0;
                exp_pc    = s_rpc;
                m_valid   = 1'b0;
                m_instr   = NOP;
            end else begin
                if (exp_q.size() > 0 && !front_got && s_rvalid)
                    front_got = 1'b1;
                if (!s_stall) begin
                    if (exp_q.size() > 0 && front_got) begin
                        predicted = 1'b1;
                    end else begin
                        m_valid = 1'b0;
                        m_instr = NOP;
                    end
                end
            end
            observed = !s_redir && !s_stall && (if_id_valid === 1'b1);
            if (observed)
                loads++;
            check_output("load_event", {31'b0, observed}, {31'b0, predicted});
            if (predicted) begin
                e         = exp_q.pop_front();
                front_got = 1'b0;
                m_valid   = 1'b1;
                m_pc      = e.pc;
                m_instr   = e.instr;
                exp_pc    = e.pc + 32'd4;
            end
            check_output("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
            check_output("if_id_pc", if_id_pc, m_pc);
            check_output("if_id_pc_plus4", if_id_pc_plus4, m_pc + 32'd4);
            check_output("if_id_instr", if_id_instr, m_instr);
            if (s_req)
                exp_q.push_back('{pc: exp_pc, instr: mem_word(exp_pc)});
        end
    end

    // One cycle of stimulus: memory response first, then stall/redirect chosen against it.
    task automatic apply_stimulus(input int stall_pct, input int redir_pct);
        logic [31:0] pick;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc + 1) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
        stall    = ($urandom_range(0, 99) < stall_pct);
        redirect = 1'b0;
        // A redirect on top of a stale response would leave the drain waiting forever.
        if ($urandom_range(0, 99) < redir_pct && !(mem_rvalid && exp_q.size() == 0)) begin
            case ($urandom_range(0, 3))
                0:       pick = 32'hFFFF_FFFC;
                1:       pick = 32'h0000_0100;
                2:       pick = 32'h0000_0200;
                default: pick = $urandom & 32'hFFFF_FFFC;
            endcase
            redirect    = 1'b1;
            redirect_pc = pick;
        end
    endtask

    initial begin
        int  loads_rand;
        bit  found;
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        #12;
        check_output("rst_if_id_valid", {31'b0, if_id_valid}, 32'd0);
        check_output("rst_if_id_pc", if_id_pc, 32'd0);
        check_output("rst_if_id_pc_plus4", if_id_pc_plus4, 32'd4);
        check_output("rst_if_id_instr", if_id_instr, NOP);
        check_output("rst_imem_addr", imem_addr, RESET_PC);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_output("rst_imem_req", {31'b0, imem_req}, 32'd1);

        lat_max = 1;
        repeat (20) apply_stimulus(0, 0);
        check_output("throughput_loads", loads, 32'd10);

        lat_max = 3;
        loads_rand = loads;
        repeat (3000) apply_stimulus(25, 10);
        check_output("progress", {31'b0, (loads - loads_rand) >= 100}, 32'd1);

        stall    = 1'b0;
        redirect = 1'b0;
        lat_max  = 1;
        found    = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            apply_stimulus(0, 0);
            if (imem_req) found = 1'b1;
        end
        check_output("reset_wait_found", {31'b0, found}, 32'd1);
        mem_auto   = 1'b0;
        mem_rvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        mem_q.delete();
        #2;
        check_output("midrst_if_id_valid", {31'b0, if_id_valid}, 32'd0);
        check_output("midrst_if_id_pc", if_id_pc, 32'd0);
        check_output("midrst_if_id_pc_plus4", if_id_pc_plus4, 32'd4);
        check_output("midrst_if_id_instr", if_id_instr, NOP);
        check_output("midrst_imem_addr", imem_addr, RESET_PC);
        @(negedge clk);
        rst_n      = 1'b1;
        man_rvalid = 1'b1;
        man_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        man_rvalid = 1'b0;
        mem_auto   = 1'b1;
        repeat (30) apply_stimulus(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
